vga_fb_arbiter: RTL and testbench

- Owns the single-port framebuffer RAM that feeds the VGA scan-out pixel input (16-bit q).
- Each cycle, grants the RAM to either scan-out reads or a drawing-engine write port. Scan-out always has priority.
- Upscales a FB_W x FB_H framebuffer by SCALE onto the 640x480 raster.
- Double-buffers the framebuffer, with the buffer swap synchronised to frame end.

---
 rtl/vga_fb_arbiter.sv | 173 +++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Owns the single-port framebuffer RAM. Each cycle the RAM goes either to a
// scan-out read or to the drawing-engine write port; scan-out always wins.
// The FB_W x FB_H framebuffer is upscaled by SCALE onto the 640x480 raster and
// double-buffered, with the front/back swap taking effect at frame end.
//
// Ports:
//   clock, reset           pixel clock, synchronous active-high reset
//   de_next/px_next/py_next raster position of the pixel shown 3 cycles later
//   frame_end              one-cycle pulse at start of vertical blanking
//   swap_req/swap_done     buffer swap request pulse / swap taken pulse
//   front_buf              buffer currently scanned out
//   wr_req/wr_addr/wr_data drawing-engine write (level, held until wr_ack)
//   wr_ack                 one-cycle write-accepted pulse
//   mem_addr/mem_wdata/mem_we  registered RAM command
//   mem_rdata              RAM read data, valid one cycle after mem_addr
//   pix_data               pixel word to the VGA output stage
module vga_fb_arbiter #(
    parameter int unsigned FB_W   = 160,
    parameter int unsigned FB_H   = 120,
    parameter int unsigned SCALE  = 4,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              de_next,
    input  logic [15:0]       px_next,
    input  logic [15:0]       py_next,
    input  logic              frame_end,
    input  logic              swap_req,
    output logic              swap_done,
    output logic              front_buf,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       pix_data
);

    localparam int unsigned FB_WORDS = FB_W * FB_H;
    localparam int unsigned SC_SH    = $clog2(SCALE);
    localparam int unsigned PX_MASK  = SCALE - 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } swap_state_e;

    swap_state_e       state_q, state_d;
    logic              front_buf_q, front_buf_d;
    logic              swap_done_q, swap_done_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              wr_ack_q, wr_ack_d;
    logic              rd_vld1_q, rd_vld1_d;
    logic              rd_vld2_q;
    logic [15:0]       pix_data_q, pix_data_d;

    logic [ADDR_W-1:0] front_base_c, back_base_c, rd_addr_c, wr_addr_c;
    logic              read_slot_c, wr_grant_c, wr_in_range_c;

    // Address arithmetic: scan-out reads the front buffer, writes hit the back
    always_comb begin
        front_base_c  = front_buf_q ? ADDR_W'(FB_WORDS) : '0;
        back_base_c   = front_buf_q ? '0 : ADDR_W'(FB_WORDS);
        rd_addr_c     = front_base_c
                      + ADDR_W'(32'(py_next >> SC_SH) * FB_W)
                      + ADDR_W'(px_next >> SC_SH);
        wr_addr_c     = back_base_c + wr_addr;
        wr_in_range_c = 32'(wr_addr) < FB_WORDS;
    end

    // Slot arbitration: a read is only needed on the first column of each
    // SCALE-wide pixel group; the cycle after a grant carries the ack, so a
    // still-high wr_req there belongs to the transaction being acked.
    always_comb begin
        read_slot_c = de_next && ((32'(px_next) & PX_MASK) == 32'd0);
        wr_grant_c  = !read_slot_c && wr_req && !wr_ack_q;
    end

    // RAM command and pixel pipeline next-state
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        wr_ack_d    = 1'b0;
        rd_vld1_d   = 1'b0;
        pix_data_d  = pix_data_q;
        if (read_slot_c) begin
            mem_addr_d = rd_addr_c;
            rd_vld1_d  = 1'b1;
        end else if (wr_grant_c) begin
            wr_ack_d = 1'b1;
            // Out-of-range writes are acked but never reach the RAM
            if (wr_in_range_c) begin
                mem_addr_d  = wr_addr_c;
                mem_wdata_d = wr_data;
                mem_we_d    = 1'b1;
            end
        end
        if (rd_vld2_q) begin
            pix_data_d = mem_rdata;
        end
    end

    // Swap FSM: a request waits for frame end; a coincident request swaps at once
    always_comb begin
        state_d     = state_q;
        front_buf_d = front_buf_q;
        swap_done_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (swap_req) begin
                    if (frame_end) begin
                        front_buf_d = !front_buf_q;
                        swap_done_d = 1'b1;
                    end else begin
                        state_d = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (frame_end) begin
                    front_buf_d = !front_buf_q;
                    swap_done_d = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_RUN;
            front_buf_q <= 1'b0;
            swap_done_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            wr_ack_q    <= 1'b0;
            rd_vld1_q   <= 1'b0;
            rd_vld2_q   <= 1'b0;
            pix_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            front_buf_q <= front_buf_d;
            swap_done_q <= swap_done_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            wr_ack_q    <= wr_ack_d;
            rd_vld1_q   <= rd_vld1_d;
            rd_vld2_q   <= rd_vld1_q;
            pix_data_q  <= pix_data_d;
        end
    end

    assign swap_done = swap_done_q;
    assign front_buf = front_buf_q;
    assign wr_ack    = wr_ack_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign pix_data  = pix_data_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: directed scenarios plus a randomized
// run compared against a per-buffer framebuffer model.
module tb_vga_fb_arbiter;

    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned FB_W     = 160;
    localparam int unsigned FB_H     = 120;
    localparam int unsigned SCALE    = 4;
    localparam int unsigned FB_WORDS = FB_W * FB_H;

    logic              clock = 1'b0;
    logic              reset;
    logic              de_next;
    logic [15:0]       px_next, py_next;
    logic              frame_end, swap_req, swap_done, front_buf;
    logic              wr_req, wr_ack;
    logic [ADDR_W-1:0] wr_addr, mem_addr;
    logic [15:0]       wr_data, mem_wdata, mem_rdata, pix_data;
    logic              mem_we;

    int total = 0;
    int bad   = 0;

    // Behavioural RAM with one cycle read latency, plus an override for directed reads
    logic [15:0] ram [0:65535];
    logic [15:0] ram_q;
    logic        ram_clr = 1'b0;
    logic        ovr_en  = 1'b0;
    logic [15:0] ovr_val = 16'h0;

    always @(posedge clock) begin
        if (ram_clr) begin
            for (int i = 0; i < 65536; i++) ram[i] <= 16'h0;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        ram_q <= ram[mem_addr];
    end
    assign mem_rdata = ovr_en ? ovr_val : ram_q;

    // Reference framebuffer contents per buffer
    logic [15:0] mfb [2][FB_WORDS];

    always #5 clock = ~clock;

    vga_fb_arbiter #(.FB_W(FB_W), .FB_H(FB_H), .SCALE(SCALE), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .de_next(de_next), .px_next(px_next),
        .py_next(py_next), .frame_end(frame_end), .swap_req(swap_req),
        .swap_done(swap_done), .front_buf(front_buf), .wr_req(wr_req),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .pix_data(pix_data)
    );

    task cyc();
        @(posedge clock);
        #1;
    endtask

    task idle();
        de_next = 1'b0; px_next = 16'd0; py_next = 16'd0;
        frame_end = 1'b0; swap_req = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_data = 16'h0;
    endtask

    task test_reset();
        idle();
        reset = 1'b1; ram_clr = 1'b1;
        repeat (3) cyc();
        ram_clr = 1'b0;
        total++; if (mem_addr !== '0)      begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        total++; if (mem_wdata !== 16'h0)  begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
        total++; if (mem_we !== 1'b0)      begin bad++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        total++; if (wr_ack !== 1'b0)      begin bad++; $display("FAIL reset_wr_ack got=%b exp=0", wr_ack); end
        total++; if (pix_data !== 16'h0)   begin bad++; $display("FAIL reset_pix got=%h exp=0", pix_data); end
        total++; if (front_buf !== 1'b0)   begin bad++; $display("FAIL reset_front got=%b exp=0", front_buf); end
        total++; if (swap_done !== 1'b0)   begin bad++; $display("FAIL reset_swap_done got=%b exp=0", swap_done); end
        reset = 1'b0;
        cyc();
    endtask

    task test_scan_addr();
        ovr_en = 1'b1; ovr_val = 16'hABCD;
        de_next = 1'b1; px_next = 16'd8; py_next = 16'd5;
        cyc();
        total++; if (mem_addr !== 16'd162) begin bad++; $display("FAIL scan_addr got=%0d exp=162", mem_addr); end
        total++; if (mem_we !== 1'b0)      begin bad++; $display("FAIL scan_we got=%b exp=0", mem_we); end
        total++; if (pix_data !== 16'h0)   begin bad++; $display("FAIL scan_pix_early1 got=%h exp=0", pix_data); end
        de_next = 1'b0;
        cyc();
        total++; if (pix_data !== 16'h0)   begin bad++; $display("FAIL scan_pix_early2 got=%h exp=0", pix_data); end
        for (int k = 0; k < 4; k++) begin
            cyc();
            total++; if (pix_data !== 16'hABCD) begin bad++; $display("FAIL scan_pix_hold%0d got=%h exp=abcd", k, pix_data); end
        end
        ovr_en = 1'b0;
    endtask

    task test_reset_mid_write();
        de_next = 1'b0; wr_req = 1'b1; wr_addr = 16'd3; wr_data = 16'h5555;
        reset = 1'b1;
        cyc();
        total++; if (mem_we !== 1'b0)    begin bad++; $display("FAIL rstw_we got=%b exp=0", mem_we); end
        total++; if (wr_ack !== 1'b0)    begin bad++; $display("FAIL rstw_ack got=%b exp=0", wr_ack); end
        total++; if (pix_data !== 16'h0) begin bad++; $display("FAIL rstw_pix got=%h exp=0", pix_data); end
        total++; if (front_buf !== 1'b0) begin bad++; $display("FAIL rstw_front got=%b exp=0", front_buf); end
        reset = 1'b0; wr_req = 1'b0;
        cyc();
    endtask

    task test_write_active();
        int acks;
        int gpx;
        acks = 0; gpx = -1;
        de_next = 1'b1; py_next = 16'd0;
        wr_req = 1'b1; wr_addr = 16'd5; wr_data = 16'h1234;
        for (int i = 0; i < 8; i++) begin
            px_next = 16'(i);
            cyc();
            if (wr_ack === 1'b1) begin
                acks++; gpx = i;
                total++; if (mem_addr !== 16'd19205) begin bad++; $display("FAIL wact_addr got=%0d exp=19205", mem_addr); end
                total++; if (mem_wdata !== 16'h1234) begin bad++; $display("FAIL wact_wdata got=%h exp=1234", mem_wdata); end
                wr_req = 1'b0;
            end
            total++; if (mem_we !== wr_ack) begin bad++; $display("FAIL wact_we_vs_ack px=%0d we=%b exp=%b", i, mem_we, wr_ack); end
        end
        total++; if (acks != 1) begin bad++; $display("FAIL wact_ack_count got=%0d exp=1", acks); end
        total++; if (gpx != 1)  begin bad++; $display("FAIL wact_grant_px got=%0d exp=1", gpx); end
        de_next = 1'b0; wr_req = 1'b0;
        cyc();
    endtask

    task test_oor();
        int acks;
        acks = 0;
        de_next = 1'b0; wr_req = 1'b1; wr_addr = 16'd19200; wr_data = 16'hBEEF;
        for (int i = 0; i < 6; i++) begin
            cyc();
            total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL oor_we cyc=%0d got=%b exp=0", i, mem_we); end
            if (wr_ack === 1'b1) begin acks++; wr_req = 1'b0; end
        end
        total++; if (acks != 1) begin bad++; $display("FAIL oor_ack_count got=%0d exp=1", acks); end
    endtask

    task test_swap();
        int dones;
        dones = 0;
        idle();
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        if (swap_done === 1'b1) dones++;
        for (int i = 0; i < 10; i++) begin cyc(); if (swap_done === 1'b1) dones++; end
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        if (swap_done === 1'b1) dones++;
        for (int i = 0; i < 88; i++) begin cyc(); if (swap_done === 1'b1) dones++; end
        total++; if (front_buf !== 1'b0) begin bad++; $display("FAIL swap_front_before got=%b exp=0", front_buf); end
        frame_end = 1'b1;
        cyc();
        frame_end = 1'b0;
        total++; if (swap_done !== 1'b1) begin bad++; $display("FAIL swap_done_pulse got=%b exp=1", swap_done); end
        total++; if (front_buf !== 1'b1) begin bad++; $display("FAIL swap_front_after got=%b exp=1", front_buf); end
        if (swap_done === 1'b1) dones++;
        for (int i = 0; i < 4; i++) begin cyc(); if (swap_done === 1'b1) dones++; end
        total++; if (dones != 1) begin bad++; $display("FAIL swap_done_count got=%0d exp=1", dones); end
        de_next = 1'b1; px_next = 16'd0; py_next = 16'd0;
        cyc();
        total++; if (mem_addr !== 16'd19200) begin bad++; $display("FAIL swap_read_addr got=%0d exp=19200", mem_addr); end
        de_next = 1'b0; wr_req = 1'b1; wr_addr = 16'd0; wr_data = 16'h0F0F;
        cyc();
        total++; if (wr_ack !== 1'b1)   begin bad++; $display("FAIL swap_write_ack got=%b exp=1", wr_ack); end
        total++; if (mem_we !== 1'b1)   begin bad++; $display("FAIL swap_write_we got=%b exp=1", mem_we); end
        total++; if (mem_addr !== 16'd0) begin bad++; $display("FAIL swap_write_addr got=%0d exp=0", mem_addr); end
        wr_req = 1'b0;
        cyc();
    endtask

    task test_coincident();
        idle();
        swap_req = 1'b1; frame_end = 1'b1;
        cyc();
        swap_req = 1'b0; frame_end = 1'b0;
        total++; if (front_buf !== 1'b0) begin bad++; $display("FAIL coin_front got=%b exp=0", front_buf); end
        total++; if (swap_done !== 1'b1) begin bad++; $display("FAIL coin_done got=%b exp=1", swap_done); end
        cyc();
        total++; if (swap_done !== 1'b0) begin bad++; $display("FAIL coin_done_clear got=%b exp=0", swap_done); end
        // Back in RUN: a bare frame_end must not swap
        frame_end = 1'b1;
        cyc();
        frame_end = 1'b0;
        total++; if (swap_done !== 1'b0) begin bad++; $display("FAIL coin_run_done got=%b exp=0", swap_done); end
        total++; if (front_buf !== 1'b0) begin bad++; $display("FAIL coin_run_front got=%b exp=0", front_buf); end
        cyc();
    endtask

    task test_random();
        int          n, idx;
        bit          m_front, m_pend, m_ack, exp_done, exp_we, addr_known, req_active, rd, gnt;
        logic [15:0] exp_pix, exp_wd;
        int          exp_addr;
        int          due_q[$];
        logic [15:0] val_q[$];
        idle();
        reset = 1'b1; ram_clr = 1'b1;
        cyc();
        ram_clr = 1'b0;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < int'(FB_WORDS); i++) begin mfb[0][i] = 16'h0; mfb[1][i] = 16'h0; end
        m_front = 0; m_pend = 0; m_ack = 0; exp_done = 0; exp_we = 0;
        addr_known = 1; req_active = 0;
        exp_pix = 16'h0; exp_wd = 16'h0; exp_addr = 0; n = 0;
        for (int c = 0; c < 4000; c++) begin
            de_next = ($urandom_range(0, 3) != 0);
            px_next = 16'($urandom_range(0, 159) * 4 + ($urandom_range(0, 1) != 0 ? 0 : $urandom_range(1, 3)));
            py_next = 16'($urandom_range(0, 479));
            if (!req_active && $urandom_range(0, 1) != 0) begin
                req_active = 1;
                wr_addr = ($urandom_range(0, 15) == 0) ? ADDR_W'(FB_WORDS + $urandom_range(0, 100))
                                                       : ADDR_W'($urandom_range(0, FB_WORDS - 1));
                wr_data = 16'($urandom);
            end
            wr_req    = req_active;
            swap_req  = ($urandom_range(0, 19) == 0);
            frame_end = ($urandom_range(0, 29) == 0);

            rd  = de_next && (px_next % 4 == 0);
            gnt = !rd && wr_req && !m_ack;
            exp_we = 0;
            if (rd) begin
                idx = int'(py_next / 4) * int'(FB_W) + int'(px_next / 4);
                due_q.push_back(n + 3);
                val_q.push_back(mfb[m_front][idx]);
                exp_addr = (m_front ? int'(FB_WORDS) : 0) + idx;
                addr_known = 1;
            end else if (gnt) begin
                if (int'(wr_addr) < int'(FB_WORDS)) begin
                    exp_we = 1;
                    exp_wd = wr_data;
                    exp_addr = (m_front ? 0 : int'(FB_WORDS)) + int'(wr_addr);
                    addr_known = 1;
                    mfb[!m_front][int'(wr_addr)] = wr_data;
                end else begin
                    addr_known = 0;
                end
            end
            m_ack = gnt;
            if (frame_end && (m_pend || swap_req)) begin
                m_front = !m_front; exp_done = 1; m_pend = 0;
            end else begin
                exp_done = 0;
                if (swap_req) m_pend = 1;
            end

            cyc();
            n++;
            while (due_q.size() > 0 && due_q[0] == n) begin
                exp_pix = val_q.pop_front();
                void'(due_q.pop_front());
            end
            if (m_ack) req_active = 0;

            total++; if (wr_ack !== m_ack)      begin bad++; $display("FAIL rnd_ack c=%0d got=%b exp=%b", c, wr_ack, m_ack); end
            total++; if (mem_we !== exp_we)     begin bad++; $display("FAIL rnd_we c=%0d got=%b exp=%b", c, mem_we, exp_we); end
            if (exp_we) begin
                total++; if (mem_wdata !== exp_wd) begin bad++; $display("FAIL rnd_wdata c=%0d got=%h exp=%h", c, mem_wdata, exp_wd); end
            end
            if (addr_known) begin
                total++; if (mem_addr !== ADDR_W'(exp_addr)) begin bad++; $display("FAIL rnd_addr c=%0d got=%0d exp=%0d", c, mem_addr, exp_addr); end
            end
            total++; if (front_buf !== m_front) begin bad++; $display("FAIL rnd_front c=%0d got=%b exp=%b", c, front_buf, m_front); end
            total++; if (swap_done !== exp_done) begin bad++; $display("FAIL rnd_done c=%0d got=%b exp=%b", c, swap_done, exp_done); end
            total++; if (pix_data !== exp_pix)  begin bad++; $display("FAIL rnd_pix c=%0d got=%h exp=%h", c, pix_data, exp_pix); end
        end
        idle();
        cyc();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_scan_addr();
        test_reset_mid_write();
        test_write_active();
        test_oor();
        test_swap();
        test_coincident();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
